// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 800x600@60 timing constants and sequencer state type
package vga_timing_pkg;

    localparam int VGA_DATA_W   = 8;
    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 40;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BP     = 88;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BP     = 23;
    localparam int VGA_IMG_COLS = 512;
    localparam int VGA_IMG_ROWS = 512;
    localparam int VGA_FRM_W    = 16;

    // Line and frame totals; porches come before the active region.
    localparam int VGA_H_TOTAL = VGA_H_FP + VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE;
    localparam int VGA_V_TOTAL = VGA_V_FP + VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE;

    // Top-left corner of the image window in counter coordinates.
    localparam int VGA_X0 = VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_Y0 = VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } seq_state_t;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_xy_counter.sv
// rtl/vga_xy_counter.sv - scan position counters with enable and frame wrap
module vga_xy_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_TOTAL = VGA_V_TOTAL,
    parameter int XW      = cnt_width(VGA_H_TOTAL + 1),
    parameter int YW      = cnt_width(VGA_V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          end_of_frame
);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    assign end_of_frame = (x == X_LAST) && (y == Y_LAST);

    // Advance x every enabled cycle, y on x wrap; hold both at 0 when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (!en) begin
            x <= '0;
            y <= '0;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
            x <= x + XW'(1);
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// rtl/vga_frame_sequencer.sv - VGA scan-out sequencer pulling image bytes from a ready/valid source
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int DATA_W   = VGA_DATA_W,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int IMG_COLS = VGA_IMG_COLS,
    parameter int IMG_ROWS = VGA_IMG_ROWS,
    parameter int FRM_W    = VGA_FRM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [FRM_W-1:0]  num_frames,
    input  logic [DATA_W-1:0] pix_in_data,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] G,
    output logic [DATA_W-1:0] B,
    output logic              HS,
    output logic              VS,
    output logic              busy,
    output logic              frame_done,
    output logic [FRM_W-1:0]  frame_cnt,
    output logic              underflow
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int X0      = H_FP + H_SYNC + H_BP;
    localparam int Y0      = V_FP + V_SYNC + V_BP;

    // One spare code so window end bounds equal to the total still fit.
    localparam int XW = cnt_width(H_TOTAL + 1);
    localparam int YW = cnt_width(V_TOTAL + 1);

    localparam logic [XW-1:0] HS_BEG    = XW'(H_FP);
    localparam logic [XW-1:0] HS_END    = XW'(H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_BEG    = YW'(V_FP);
    localparam logic [YW-1:0] VS_END    = YW'(V_FP + V_SYNC);
    localparam logic [XW-1:0] IMG_X_BEG = XW'(X0);
    localparam logic [XW-1:0] IMG_X_END = XW'(X0 + IMG_COLS);
    localparam logic [YW-1:0] IMG_Y_BEG = YW'(Y0);
    localparam logic [YW-1:0] IMG_Y_END = YW'(Y0 + IMG_ROWS);

    seq_state_t        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              end_of_frame;
    logic [FRM_W-1:0]  frames_lat;
    logic              stop_pending;
    logic              run;
    logic              hs_on;
    logic              vs_on;
    logic              in_img;
    logic              xfer;
    logic              last_frame;

    vga_xy_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .XW      (XW),
        .YW      (YW)
    ) u_xy (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (run),
        .x            (x),
        .y            (y),
        .end_of_frame (end_of_frame)
    );

    assign run    = (state == RUN);
    assign hs_on  = (x >= HS_BEG) && (x < HS_END);
    assign vs_on  = (y >= VS_BEG) && (y < VS_END);
    assign in_img = (x >= IMG_X_BEG) && (x < IMG_X_END) &&
                    (y >= IMG_Y_BEG) && (y < IMG_Y_END);

    // The source is only asked for a byte inside the image window while running.
    assign pix_in_ready = run && in_img;
    assign xfer         = pix_in_ready && pix_in_valid;
    assign busy         = (state != IDLE);

    // The frame now finishing is the last requested one (0 requests run forever).
    assign last_frame = (frames_lat != '0) &&
                        (({1'b0, frame_cnt} + (FRM_W + 1)'(1)) == {1'b0, frames_lat});

    // Sequencing FSM: command handling, frame accounting and underflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frames_lat   <= '0;
            frame_cnt    <= '0;
            underflow    <= 1'b0;
            stop_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A missing byte is not waited for; the slot is emitted as black.
            if (pix_in_ready && !pix_in_valid) begin
                underflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // start has priority over a simultaneous stop here.
                    if (start) begin
                        frames_lat   <= num_frames;
                        frame_cnt    <= '0;
                        underflow    <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= PRIME;
                    end
                end
                PRIME: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (pix_in_valid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Stop is graceful: remembered and honoured at end of frame.
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (end_of_frame) begin
                        frame_done <= 1'b1;
                        if (frame_cnt != '1) begin
                            frame_cnt <= frame_cnt + FRM_W'(1);
                        end
                        if (stop || stop_pending || last_frame) begin
                            stop_pending <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered sync and pixel outputs, one cycle behind the counter position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HS <= 1'b1;
            VS <= 1'b1;
            R  <= '0;
            G  <= '0;
            B  <= '0;
        end else begin
            HS <= ~(run && hs_on);
            VS <= ~(run && vs_on);
            R  <= xfer ? pix_in_data : '0;
            G  <= xfer ? pix_in_data : '0;
            B  <= xfer ? pix_in_data : '0;
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb/tb_vga_frame_sequencer.sv - scoreboard bench for vga_frame_sequencer on a reduced raster
module tb_vga_frame_sequencer;

    localparam int DW  = 8;
    localparam int HA  = 12;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 2;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int IC  = 8;
    localparam int IR  = 6;
    localparam int FW  = 4;

    localparam int HT    = HFP + HSY + HBP + HA;
    localparam int VT    = VFP + VSY + VBP + VA;
    localparam int FRAME = HT * VT;
    localparam int X0    = HFP + HSY + HBP;
    localparam int Y0    = VFP + VSY + VBP;
    localparam int CMAX  = (1 << FW) - 1;
    localparam int OW    = 3 * DW + FW + 5;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    localparam logic [OW-1:0] RST_OUT = {2'b11, (OW - 2)'(0)};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [FW-1:0] num_frames = '0;
    logic [DW-1:0] pix_in_data = '0;
    logic          pix_in_valid = 1'b0;
    logic          pix_in_ready;
    logic [DW-1:0] R, G, B;
    logic          HS, VS, busy, frame_done, underflow;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .DATA_W(DW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .IMG_COLS(IC), .IMG_ROWS(IR), .FRM_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_frames(num_frames),
        .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .underflow(underflow)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [OW-1:0] dut_out();
        return {HS, VS, R, G, B, frame_done, frame_cnt, busy, underflow};
    endfunction

    // Reference model: scan position is a single frame-relative cycle index m_t.
    int            m_st, m_t, m_nf, m_cnt;
    bit            m_uf, m_sp;
    logic [OW-1:0] exp_out;

    task automatic model_reset();
        m_st = M_IDLE; m_t = 0; m_nf = 0; m_cnt = 0; m_uf = 0; m_sp = 0;
        exp_out = RST_OUT;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit v, input logic [DW-1:0] d,
                              input int nf, output bit rdy);
        int x, y;
        bit run, hs, vs, fd, finish_now;
        logic [DW-1:0] pix;
        run = (m_st == M_RUN);
        x = m_t % HT;
        y = m_t / HT;
        rdy = run && x >= X0 && x < X0 + IC && y >= Y0 && y < Y0 + IR;
        hs  = !(run && x >= HFP && x < HFP + HSY);
        vs  = !(run && y >= VFP && y < VFP + VSY);
        pix = (rdy && v) ? d : '0;
        fd  = run && (m_t == FRAME - 1);
        if (rdy && !v) m_uf = 1;
        if (m_st == M_IDLE) begin
            if (st) begin
                m_nf = nf; m_cnt = 0; m_uf = 0; m_sp = 0; m_st = M_PRIME;
            end
        end else if (m_st == M_PRIME) begin
            if (sp) m_st = M_IDLE;
            else if (v) begin m_st = M_RUN; m_t = 0; end
        end else begin
            if (sp) m_sp = 1;
            if (m_t == FRAME - 1) begin
                finish_now = m_sp || (m_nf != 0 && m_cnt + 1 == m_nf);
                if (m_cnt < CMAX) m_cnt++;
                m_t = 0;
                if (finish_now) begin m_st = M_IDLE; m_sp = 0; end
            end else begin
                m_t++;
            end
        end
        exp_out = {hs, vs, pix, pix, pix, fd, FW'(m_cnt), (m_st != M_IDLE), m_uf};
    endtask

    // Scoreboard queues, filled by stimulus and drained by the monitor.
    bit            q_rdy[$];
    logic [OW-1:0] q_out[$];
    bit            mon_en = 0;

    initial begin
        bit            e;
        logic [OW-1:0] eo;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q_rdy.size() > 0) begin
                    e = q_rdy.pop_front();
                    chk(pix_in_ready === e, "pix_in_ready", longint'(pix_in_ready), longint'(e));
                end
                if (q_out.size() >= 2) begin
                    eo = q_out.pop_front();
                    chk(dut_out() === eo, "outputs{HS,VS,R,G,B,fd,cnt,busy,uf}",
                        longint'(dut_out()), longint'(eo));
                end
            end
        end
    end

    // Stimulus drivers and observation statistics.
    bit            drv_start = 0, drv_stop = 0, drv_valid = 0, inc_data = 0;
    int            drv_nf = 0;
    logic [DW-1:0] drv_data = '0;
    int            cyc_idx = 0, n_rdy = 0, n_hs = 0, n_vs = 0, n_fd = 0, first_rdy = -1, fd_idx = -1;

    task automatic clr_stats();
        n_rdy = 0; n_hs = 0; n_vs = 0; n_fd = 0; first_rdy = -1; fd_idx = -1;
    endtask

    task automatic tick();
        bit r;
        @(posedge clk);
        #2;
        drv_data     = inc_data ? drv_data + 8'd1 : DW'($urandom);
        start        = drv_start;
        stop         = drv_stop;
        pix_in_valid = drv_valid;
        pix_in_data  = drv_data;
        num_frames   = FW'(drv_nf);
        model_step(drv_start, drv_stop, drv_valid, drv_data, drv_nf, r);
        q_rdy.push_back(r);
        q_out.push_back(exp_out);
        #1;
        if (pix_in_ready === 1'b1) begin
            n_rdy++;
            if (first_rdy < 0) first_rdy = cyc_idx;
        end
        if (HS === 1'b0) n_hs++;
        if (VS === 1'b0) n_vs++;
        if (frame_done === 1'b1) begin n_fd++; fd_idx = cyc_idx; end
        cyc_idx++;
        drv_start = 0;
        drv_stop  = 0;
    endtask

    // vmode: 0 valid high, 1 random ~90% valid, 2 valid low
    task automatic run_n(input int n, input int vmode);
        for (int i = 0; i < n; i++) begin
            drv_valid = (vmode == 0) ? 1'b1 : (vmode == 2) ? 1'b0 : ($urandom_range(0, 9) != 0);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        mon_en = 0;
        @(posedge clk);
        #2;
        rst_n = 0; start = 0; stop = 0; pix_in_valid = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(pix_in_ready === 1'b0, "reset_ready", longint'(pix_in_ready), 0);
            if (i == 0 || i == n - 1)
                chk(dut_out() === RST_OUT, "reset_outputs", longint'(dut_out()), longint'(RST_OUT));
        end
        @(posedge clk);
        #2;
        rst_n = 1; pix_in_valid = 0;
        model_reset();
        q_rdy.delete();
        q_out.delete();
        q_out.push_back(exp_out);
        mon_en = 1;
    endtask

    initial begin
        int s, u;
        model_reset();
        do_reset(100);

        // Single frame, always valid, incrementing bytes.
        inc_data = 1; drv_nf = 1; drv_valid = 1;
        clr_stats();
        s = cyc_idx;
        drv_start = 1; tick();
        run_n(FRAME + 20, 0);
        chk(first_rdy - (s + 2) == Y0 * HT + X0, "first_ready_offset", first_rdy - (s + 2), Y0 * HT + X0);
        chk(n_rdy == IC * IR, "transfer_count", n_rdy, IC * IR);
        chk(n_hs == HSY * VT, "hs_low_cycles", n_hs, HSY * VT);
        chk(n_vs == VSY * HT, "vs_low_cycles", n_vs, VSY * HT);
        chk(n_fd == 1, "frame_done_count", n_fd, 1);
        chk(fd_idx - (s + 2) == FRAME, "frame_done_offset", fd_idx - (s + 2), FRAME);
        chk(frame_cnt === FW'(1), "single_frame_cnt", longint'(frame_cnt), 1);
        chk(busy === 1'b0, "single_frame_idle", longint'(busy), 0);
        inc_data = 0;

        // Graceful stop midway through the second frame.
        drv_nf = 0; drv_valid = 1; drv_start = 1; tick();
        for (int i = 0; i < 3 * FRAME && !(m_st == M_RUN && m_cnt == 1 && m_t == FRAME / 2); i++)
            run_n(1, 1);
        chk(frame_cnt === FW'(1), "stop_point_cnt", longint'(frame_cnt), 1);
        drv_stop = 1; tick();
        run_n(FRAME + 40, 1);
        chk(frame_cnt === FW'(2), "stop_final_cnt", longint'(frame_cnt), 2);
        chk(busy === 1'b0, "stop_final_idle", longint'(busy), 0);

        // Underflow: three dropped cycles inside the window.
        clr_stats();
        u = (Y0 + 1) * HT + X0 + 2;
        drv_nf = 1; drv_valid = 1; s = cyc_idx;
        drv_start = 1; tick();
        for (int i = 0; i < FRAME + 10; i++) begin
            drv_valid = !(m_st == M_RUN && m_t >= u && m_t < u + 3);
            tick();
        end
        chk(underflow === 1'b1, "underflow_sticky", longint'(underflow), 1);
        chk(fd_idx - (s + 2) == FRAME, "underflow_frame_len", fd_idx - (s + 2), FRAME);
        chk(n_rdy == IC * IR, "underflow_ready_count", n_rdy, IC * IR);

        // PRIME gating, then a stop while priming.
        clr_stats();
        drv_nf = 1; drv_valid = 0; drv_start = 1; tick();
        run_n(50, 2);
        chk(busy === 1'b1, "prime_busy", longint'(busy), 1);
        chk(n_rdy == 0, "prime_no_ready", n_rdy, 0);
        run_n(FRAME + 5, 0);
        drv_start = 1; tick();
        run_n(5, 2);
        drv_stop = 1; tick();
        run_n(5, 2);
        chk(busy === 1'b0, "prime_stop_idle", longint'(busy), 0);

        // Command corners: start in RUN ignored, start+stop in IDLE, restart clears.
        drv_nf = 2; drv_valid = 1; drv_start = 1; tick();
        run_n(100, 1);
        drv_nf = 1; drv_start = 1; tick();
        run_n(2 * FRAME, 1);
        drv_start = 1; drv_stop = 1; tick();
        run_n(3, 0);
        chk(busy === 1'b1, "start_stop_wins", longint'(busy), 1);
        run_n(FRAME, 0);

        // Reset in the middle of a frame.
        drv_nf = 0; drv_start = 1; tick();
        run_n(150, 1);
        do_reset(100);

        // Frame counter saturation.
        drv_nf = 0; drv_valid = 1; drv_start = 1; tick();
        run_n((CMAX + 2) * FRAME + 3, 0);
        chk(frame_cnt === FW'(CMAX), "frame_cnt_saturates", longint'(frame_cnt), CMAX);
        drv_stop = 1; tick();
        run_n(FRAME + 5, 0);

        // Randomized command and source behaviour.
        for (int i = 0; i < 6000; i++) begin
            drv_start = ($urandom_range(0, 149) == 0);
            drv_stop  = ($urandom_range(0, 249) == 0);
            drv_nf    = $urandom_range(0, 3);
            drv_valid = ($urandom_range(0, 6) != 0);
            tick();
        end
        run_n(2, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
